alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the combinational datapath ALU. It adds a persistent 5-bit program status register (PSR), a valid/ready input handshake, a registered result, signed variable shifts and a multi-cycle shift-add multiplier. It sits between the register-file read ports and write-back in the datapath; the controller issues one operation per accepted cycle.

## Interface
- `WIDTH`, default 16: operand and result width, ≥ 4.
- `SAW`, default $clog2(WIDTH)+1: width of the signed shift-amount field, taken from `b[SAW-1:0]`.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low; one clock, sampled on the rising edge.
- `in_valid`  in  1: operation present on `op`, `a` and `b`.
- `in_ready`  out  1: the block can accept; equals `rst_n && state==IDLE`.
- `op`  in  4: operation code; see Operation.
- `a`, `b`  in  WIDTH each: operands. Immediates arrive already sign- or zero-extended.
- `result`  out  WIDTH: registered result.
- `out_valid`  out  1: one-cycle pulse, `result` is new.
- `psr`  out  5: flags register. [0] C carry/borrow, [1] L unsigned-less, [2] F signed overflow, [3] Z zero, [4] N signed-less/negative.

## Operation
- An op is accepted on an edge where `in_valid && in_ready`. `op`, `a` and `b` are sampled only at acceptance.
- Op codes and PSR effect. Flags not listed keep their value:
  - 0 NOP: result 0, no `out_valid`.
  - 1 ADD: `a+b`. C = carry out. F = signed overflow. Z and N from the result MSB and zero test.
  - 2 ADDU: `a+b`, PSR unchanged.
  - 3 ADDC: `a+b+psr.C`, using the C value at acceptance. Updates C, F, Z, N as ADD does.
  - 4 SUB: `a-b`. C = borrow (`a<b` unsigned). F = signed overflow: operand signs differ and result sign ≠ `a` sign. Z and N from the result.
  - 5 CMP: result 0. Z = (`a==b`), L = (`a<b` unsigned), N = (`a<b` signed). C and F are unchanged. `out_valid` pulses.
  - 6 ADDCU: `a+b+psr.C`, PSR unchanged.
  - 7 AND, 8 OR, 9 XOR: bitwise, PSR unchanged.
  - 10 NOT: bitwise `~a`, PSR unchanged.
  - 11 LSH: s = signed `b[SAW-1:0]`. s ≥ 0 shifts `a` left by s. s < 0 shifts right logically by -s. |s| ≥ WIDTH gives 0.
  - 12 ASH: as LSH, but right shifts fill with `a[WIDTH-1]`. A right shift with |s| ≥ WIDTH gives all sign bits.
  - 13 MUL: low WIDTH bits of `a*b`, multi-cycle. Sets Z and N from the result.
  - 14 PSRW: `psr <= b[4:0]`, result 0.
  - 15 reserved: behaves as NOP.
- FSM has two states: IDLE and MUL.
  - IDLE: accepting a non-MUL op writes `result` and `psr` on the same edge and sets `out_valid` for the next cycle. The state stays IDLE.
  - IDLE→MUL on accepting op 13. Operands are latched into a multiplicand register and a multiplier register, the accumulator is cleared, and `cnt` = 0.
  - MUL, each edge: if multiplier LSB = 1, add the multiplicand to the accumulator. Shift the multiplicand left by 1 and the multiplier right by 1. `cnt++`.
  - MUL→IDLE on the edge where `cnt==WIDTH-1`. That edge writes `result` = final accumulator, updates Z and N, and sets `out_valid`.
- `in_valid` while `in_ready`=0 is ignored, not queued. Holding the op until it is accepted is the controller's job.
- Back-to-back ops see the PSR written by the previous op, because `psr` updates on the accept edge.

## Timing
- Reset, on any edge with `rst_n`=0: `result`=0, `psr`=0, `out_valid`=0, state IDLE, `cnt`=0. `in_ready`=0 while reset is asserted and 1 in the first cycle after it is released.
- Reset in the middle of a MUL aborts it. No `out_valid` is produced and the partial result is discarded.
- Single-cycle ops:
  - Accept on edge E0 → `out_valid`=1 and `result` valid in the cycle after E0.
  - Throughput is 1 op per cycle.
- MUL:
  - Accept on E0. Iterations occur on edges E1..E_WIDTH.
  - `out_valid`=1 in the cycle after E_WIDTH, i.e. WIDTH+1 edges after acceptance.
  - `in_ready`=0 from the cycle after E0 through E_WIDTH. It is 1 again in the cycle where `out_valid`=1, so a new op may be accepted in that cycle.
- `out_valid` is high for exactly one cycle per producing op. It is never asserted for NOP or reserved codes.
- `result` holds its value until the next producing op.

## Test plan
All scenarios use WIDTH=16.
- ADD `a`=0x7FFF, `b`=0x0001 → `result`=0x8000 with `out_valid` one cycle later. PSR: F=1, N=1, C=0, Z=0.
- ADD 0xFFFF+0x0001, then ADDC 0x0001+0x0001 back to back. First gives 0x0000 with C=1, Z=1. Second gives 0x0003 with C=0, Z=0.
- CMP `a`=0x0001, `b`=0xFFFF after a SUB that left C=1 → `result`=0, L=1, N=0, Z=0, C still 1.
- Shifts:
  - LSH 0x00F0 by `b`=0x1C (-4) → 0x000F.
  - ASH 0x8000 by 0x1F (-1) → 0xC000.
  - LSH 0x1234 by 0x10 (-16) → 0x0000.
  - LSH 0x0001 by 0x0F → 0x8000.
- MUL 0x0003×0xFFFF → 0xFFFD with N=1. `in_ready` is low for 16 cycles and `out_valid` comes 17 edges after acceptance. An ADD offered during the busy window is not executed.
- Drop `rst_n` at MUL iteration 5 → `out_valid` never pulses, `psr`=0 and `result`=0. `in_ready`=1 in the first cycle after release, and the next ADD 2+3 returns 0x0005.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a persistent program status register.
//
// Sits between the register-file read ports and write-back. The
// controller offers one operation per cycle on op/a/b with in_valid; an
// operation is taken on any rising edge where in_valid && in_ready.
// Single-cycle ops write result/psr on the accept edge. MUL runs a
// WIDTH-iteration shift-add loop and reports WIDTH+1 edges after accept.
//
// Parameters
//   WIDTH  operand/result width (>= 4)
//   SAW    width of the signed shift amount taken from b[SAW-1:0]
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   op/a/b carry an operation
//   in_ready   block can accept (reset released and not multiplying)
//   op         operation code
//   a, b       operands
//   result     registered result, held until the next producing op
//   out_valid  one-cycle pulse: result is new
//   psr        flags {N, Z, F, L, C}
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SAW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [4:0]       psr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam int FC = 0;
  localparam int FL = 1;
  localparam int FF = 2;
  localparam int FZ = 3;
  localparam int FN = 4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADDU  = 4'd2;
  localparam logic [3:0] OP_ADDC  = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_CMP   = 4'd5;
  localparam logic [3:0] OP_ADDCU = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NOT   = 4'd10;
  localparam logic [3:0] OP_LSH   = 4'd11;
  localparam logic [3:0] OP_ASH   = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_PSRW  = 4'd14;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt;

  logic [WIDTH-1:0] result_p1;
  logic [4:0]       psr_p1;
  logic             vld_p1;

  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;

  logic             accept;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_psr;
  logic             alu_prod;
  logic signed [WIDTH-1:0] a_s, b_s;

  // Two's-complement overflow: same-sign addends produce opposite-sign sum.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Subtract overflow: operand signs differ and the result sign left a's sign.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Signed variable shift: non-negative amounts shift left, negative amounts
  // shift right by the magnitude. Magnitudes of WIDTH or more saturate to
  // zero, or to all sign bits for an arithmetic right shift.
  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] val,
                                                input logic [SAW-1:0]   amt,
                                                input logic             arith);
    logic [SAW-1:0]          mag;
    logic signed [WIDTH-1:0] sval;
    logic [WIDTH-1:0]        r;
    sval = val;
    mag  = amt[SAW-1] ? (~amt + {{(SAW-1){1'b0}}, 1'b1}) : amt;
    if ({1'b0, mag} >= (SAW+1)'(WIDTH))
      r = (amt[SAW-1] && arith) ? {WIDTH{val[WIDTH-1]}} : '0;
    else if (!amt[SAW-1])
      r = val << mag;
    else if (arith)
      r = sval >>> mag;
    else
      r = val >> mag;
    return r;
  endfunction

  assign in_ready = rst_n && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign a_s      = a;
  assign b_s      = b;

  // Single-cycle datapath: computes the result and the PSR that an op would
  // commit if accepted this cycle. Flags not touched by an op pass through.
  always_comb begin
    sum_x    = '0;
    alu_res  = '0;
    alu_psr  = psr_p1;
    alu_prod = 1'b1;
    case (op)
      OP_ADD, OP_ADDC: begin
        sum_x = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) & psr_p1[FC]};
        alu_res     = sum_x[WIDTH-1:0];
        alu_psr[FC] = sum_x[WIDTH];
        alu_psr[FF] = add_ovf(a, b, alu_res);
        alu_psr[FZ] = ~|alu_res;
        alu_psr[FN] = alu_res[WIDTH-1];
      end
      OP_ADDU, OP_ADDCU: begin
        sum_x   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDCU) & psr_p1[FC]};
        alu_res = sum_x[WIDTH-1:0];
      end
      OP_SUB: begin
        // The extra top bit of the difference is the borrow (a < b unsigned).
        sum_x       = {1'b0, a} - {1'b0, b};
        alu_res     = sum_x[WIDTH-1:0];
        alu_psr[FC] = sum_x[WIDTH];
        alu_psr[FF] = sub_ovf(a, b, alu_res);
        alu_psr[FZ] = ~|alu_res;
        alu_psr[FN] = alu_res[WIDTH-1];
      end
      OP_CMP: begin
        alu_psr[FZ] = (a == b);
        alu_psr[FL] = (a < b);
        alu_psr[FN] = (a_s < b_s);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_LSH:  alu_res = shift_fn(a, b[SAW-1:0], 1'b0);
      OP_ASH:  alu_res = shift_fn(a, b[SAW-1:0], 1'b1);
      OP_MUL:  alu_prod = 1'b0;
      OP_PSRW: alu_psr = 5'(b);
      default: alu_prod = 1'b0;
    endcase
  end

  // One shift-add step; on the last iteration this is the final product.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (op == OP_MUL)) state_d = MUL;
      MUL:     if (cnt == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p1: accept edge / final multiply edge commits result & psr ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt       <= '0;
      result_p1 <= '0;
      psr_p1    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          if (op == OP_MUL) begin
            cnt <= '0;
          end else if (alu_prod) begin
            result_p1 <= alu_res;
            psr_p1    <= alu_psr;
            vld_p1    <= 1'b1;
          end
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          result_p1  <= acc_nxt;
          psr_p1[FZ] <= ~|acc_nxt;
          psr_p1[FN] <= acc_nxt[WIDTH-1];
          vld_p1     <= 1'b1;
        end
      end
    end
  end

  // Multiplier operand/accumulator registers: loaded at accept, so they need
  // no reset; an aborted multiply simply leaves stale values behind.
  always_ff @(posedge clk) begin
    if (accept && (op == OP_MUL)) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (state_q == MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end
  end

  assign result    = result_p1;
  assign psr       = psr_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W  = 16;
  localparam int SA = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         out_valid;
  logic [4:0]   psr;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SAW(SA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .result(result), .out_valid(out_valid), .psr(psr)
  );

  typedef struct {
    logic [W-1:0] r;
    logic [4:0]   p;
    int           at;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [4:0] m_psr = '0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: flags from plain integer arithmetic on the operand values.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [4:0] pin, output logic [W-1:0] r,
                                output logic [4:0] pout, output bit prod);
    longint ux, uy, sx, sy, t, s, n, m, cin;
    m    = longint'(1) << W;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    cin  = (o == 4'd3 || o == 4'd6) ? longint'(pin[0]) : 0;
    pout = pin;
    prod = 1'b1;
    t    = 0;
    case (o)
      4'd1, 4'd3: begin
        t = ux + uy + cin;
        s = sx + sy + cin;
        pout[0] = (t >= m);
        pout[2] = (s >= m / 2) || (s < -(m / 2));
      end
      4'd2, 4'd6: t = ux + uy + cin;
      4'd4: begin
        t = ux - uy;
        s = sx - sy;
        pout[0] = (ux < uy);
        pout[2] = (s >= m / 2) || (s < -(m / 2));
      end
      4'd5: begin
        pout[3] = (ux == uy);
        pout[1] = (ux < uy);
        pout[4] = (sx < sy);
      end
      4'd7:  t = ux & uy;
      4'd8:  t = ux | uy;
      4'd9:  t = ux ^ uy;
      4'd10: t = ~ux;
      4'd11, 4'd12: begin
        s = uy % (longint'(1) << SA);
        if (s >= (longint'(1) << (SA - 1))) s = s - (longint'(1) << SA);
        if (s >= 0) t = (s >= W) ? 0 : (ux << s);
        else begin
          n = -s;
          if (o == 4'd11) t = (n >= W) ? 0 : (ux >> n);
          else            t = (n >= W) ? ((sx < 0) ? -1 : 0) : (sx >>> n);
        end
      end
      4'd13: t = ux * uy;
      4'd14: pout = y[4:0];
      default: prod = 1'b0;
    endcase
    r = t[W-1:0];
    if (o == 4'd1 || o == 4'd3 || o == 4'd4 || o == 4'd13) begin
      pout[3] = (t % m == 0);
      pout[4] = (r >= W'(m / 2));
    end
  endfunction

  // Monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("result", 64'(result), 64'(mon_e.r));
        chk("psr", 64'(psr), 64'(mon_e.p));
        chk("latency", 64'(cyc), 64'(mon_e.at));
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push);
    int           guard;
    logic [W-1:0] r;
    logic [4:0]   np;
    bit           prod;
    exp_t         e;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 64'd0, 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    if (push) begin
      model(o, x, y, m_psr, r, np, prod);
      m_psr = np;
      if (prod) begin
        e.r  = r;
        e.p  = np;
        e.at = cyc + 1 + ((o == 4'd13) ? W : 0);
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_psr"}, 64'(psr), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    m_psr = '0;
    @(negedge clk);
    chk({tag, "_in_ready_high"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lo;
    reset_check("reset");

    issue(4'd1, 16'h7FFF, 16'h0001, 1);   // ADD overflow
    issue(4'd1, 16'hFFFF, 16'h0001, 1);   // ADD carry out, zero
    issue(4'd3, 16'h0001, 16'h0001, 1);   // ADDC uses C=1
    issue(4'd4, 16'h0001, 16'h0002, 1);   // SUB borrow
    issue(4'd5, 16'h0001, 16'hFFFF, 1);   // CMP keeps C
    issue(4'd11, 16'h00F0, 16'h001C, 1);  // LSH -4
    issue(4'd12, 16'h8000, 16'h001F, 1);  // ASH -1
    issue(4'd11, 16'h1234, 16'h0010, 1);  // LSH -16
    issue(4'd11, 16'h0001, 16'h000F, 1);  // LSH 15
    issue(4'd12, 16'h8001, 16'h0010, 1);  // ASH -16: all sign bits
    issue(4'd0, 16'h1111, 16'h2222, 1);   // NOP: no pulse
    issue(4'd15, 16'h1111, 16'h2222, 1);  // reserved: no pulse
    issue(4'd14, 16'h0000, 16'h0015, 1);  // PSRW
    issue(4'd6, 16'h0010, 16'h0020, 1);   // ADDCU with C=1

    // MUL with an ADD offered throughout the busy window.
    issue(4'd13, 16'h0003, 16'hFFFF, 1);
    lo = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        in_valid = 1'b0;
        break;
      end
      lo++;
      op = 4'd1; a = 16'h0005; b = 16'h0006; in_valid = 1'b1;
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", 64'(lo), 64'(W));
    issue(4'd1, 16'h0002, 16'h0003, 1);   // accepted right as MUL completes

    // Reset mid-multiply: aborted, no pulse.
    issue(4'd14, 16'h0000, 16'h001F, 1);
    issue(4'd13, 16'h1234, 16'h5678, 0);
    repeat (4) @(posedge clk);
    reset_check("abort");
    repeat (W + 4) @(negedge clk);
    issue(4'd1, 16'h0002, 16'h0003, 1);

    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), 1);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
